midi_note_tx: RTL

//  Encodes note events into 3-byte MIDI channel messages and serialises them on a 31250 baud 8N1 UART line.

---
 rtl/midi_pkg.sv | 26 ++
 rtl/midi_note_tx_if.sv | 30 +++
 rtl/midi_uart_tx.sv | 76 +++++++
 rtl/midi_note_tx.sv | 135 +++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// MIDI note transmitter shared types and constants.
// Optional feature macro: MIDI_RUNNING_STATUS_EN.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam int         MIDI_BAUD     = 31250;

  typedef enum logic [1:0] {
    IDLE,
    STATUS,
    KEY,
    VEL
  } state_t;

  function automatic state_t next_st(
    input state_t s
  );
    unique case (s)
      STATUS:  next_st = KEY;
      KEY:     next_st = VEL;
      default: next_st = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/midi_note_tx_if.sv
// Note event valid/ready handshake bundle.
// Master is the note source, slave is midi_note_tx.
interface midi_note_tx_if;

  logic       ev_valid;
  logic       ev_ready;
  logic       ev_note_on;
  logic [3:0] ev_channel;
  logic [7:0] ev_key;
  logic [7:0] ev_velocity;

  modport master (
    output ev_valid,
    output ev_note_on,
    output ev_channel,
    output ev_key,
    output ev_velocity,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_note_on,
    input  ev_channel,
    input  ev_key,
    input  ev_velocity,
    output ev_ready
  );

endinterface

// File: rtl/midi_uart_tx.sv
// 8N1 byte serialiser, DIV clocks per bit.
// Ready in the last stop-bit clock so bytes chain gaplessly.
module midi_uart_tx #(
  parameter int DIV = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       tx_o
);

  localparam int BW = $clog2(DIV);
  localparam logic [BW-1:0] LAST = BW'(DIV - 1);

  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic          stop_end;

  // bit timing and next line level
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    busy_d   = busy_q;
    tx_d     = tx_q;
    stop_end = busy_q && bit_q == 4'd9
               && baud_q == LAST;
    byte_ready_o = !busy_q || stop_end;
    if (byte_valid_i && byte_ready_o) begin
      data_d = byte_data_i;
      tx_d   = 1'b0;
      bit_d  = 4'd0;
      baud_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (baud_q == LAST) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          tx_d  = (bit_q == 4'd8) ? 1'b1
                  : data_q[bit_q[2:0]];
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  // serialiser registers, line idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q <= '0;
      bit_q  <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      data_q <= data_d;
      busy_q <= busy_d;
      tx_q   <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/midi_note_tx.sv
// Note event to 3-byte MIDI message encoder and UART sender.
// Define MIDI_RUNNING_STATUS_EN to skip repeated status bytes.
module midi_note_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = MIDI_BAUD
) (
  input  logic           clk,
  input  logic           rst_n,
  midi_note_tx_if.slave  ev,
  output logic           tx,
  output logic           busy
);

  localparam int DIV = CLK_HZ / BAUD;

  state_t     state_q, state_d;
  logic       sent_q, sent_d;
  logic [7:0] stat_q, stat_d;
  logic [7:0] key_q, key_d;
  logic [7:0] vel_q, vel_d;
  logic [7:0] status_w;
  logic [7:0] cur_b, nxt_b;
  logic       skip;
  logic       b_valid, b_ready;
  logic [7:0] b_data;

  assign status_w = {ev.ev_note_on ? MIDI_NOTE_ON
                     : MIDI_NOTE_OFF, ev.ev_channel};

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_q, last_d;
  logic       lvld_q, lvld_d;
  assign skip = lvld_q && last_q == status_w;

  // most recent status byte, invalid after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      lvld_q <= 1'b0;
    end else begin
      last_q <= last_d;
      lvld_q <= lvld_d;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // byte carried by current and following state
  always_comb begin
    unique case (state_q)
      STATUS:  begin cur_b = stat_q; nxt_b = key_q; end
      KEY:     begin cur_b = key_q;  nxt_b = vel_q; end
      default: begin cur_b = vel_q;  nxt_b = vel_q; end
    endcase
  end

  // message FSM: accept, latch, hand bytes to UART
  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    stat_d  = stat_q;
    key_d   = key_q;
    vel_d   = vel_q;
    b_valid = 1'b0;
    b_data  = cur_b;
`ifdef MIDI_RUNNING_STATUS_EN
    last_d  = last_q;
    lvld_d  = lvld_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ev.ev_valid) begin
          stat_d  = status_w;
          key_d   = ev.ev_key & 8'h7F;
          vel_d   = ev.ev_velocity & 8'h7F;
          sent_d  = 1'b0;
          state_d = skip ? KEY : STATUS;
`ifdef MIDI_RUNNING_STATUS_EN
          last_d  = status_w;
          lvld_d  = 1'b1;
`endif
        end
      end
      default: begin
        if (!sent_q) begin
          b_valid = 1'b1;
          if (b_ready) sent_d = 1'b1;
        end else if (b_ready) begin
          state_d = next_st(state_q);
          if (state_q != VEL) begin
            b_valid = 1'b1;
            b_data  = nxt_b;
          end else begin
            sent_d  = 1'b0;
          end
        end
      end
    endcase
  end

  // FSM and latched event registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sent_q  <= 1'b0;
      stat_q  <= '0;
      key_q   <= '0;
      vel_q   <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      stat_q  <= stat_d;
      key_q   <= key_d;
      vel_q   <= vel_d;
    end
  end

  assign ev.ev_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

  midi_uart_tx #(
    .DIV (DIV)
  ) u_uart (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid_i (b_valid),
    .byte_data_i  (b_data),
    .byte_ready_o (b_ready),
    .tx_o         (tx)
  );

endmodule
